// File: rtl/vga_pkg.sv
// Shared VGA geometry and line-buffer controller state encoding.
package vga_pkg;

   localparam int WIDTH_PX   = 640;
   localparam int HEIGHT_PX  = 480;
   localparam int V_TOTAL    = 525;
   localparam int TILE_WIDTH = 4;

   typedef enum logic [2:0] {
      RESET,
      PRIME_0,
      PRIME_1,
      WAIT_FRAME,
      ACTIVE
   } lcntrl_state_t;

endpackage

// File: rtl/line_buffer_cntrl.sv
// Ping-pong line buffer sequencer: primes, swaps, refills and
// maps the horizontal count onto a tile address.
module line_buffer_cntrl #(
   parameter int WIDTH_PX         = vga_pkg::WIDTH_PX,
   parameter int HEIGHT_PX        = vga_pkg::HEIGHT_PX,
   parameter int V_TOTAL          = vga_pkg::V_TOTAL,
   parameter int TILE_WIDTH       = vga_pkg::TILE_WIDTH,
   parameter int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
   parameter int TILE_ROWS        = HEIGHT_PX / TILE_WIDTH,
   parameter int LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE),
   parameter int ROW_WIDTH        = $clog2(TILE_ROWS),
   parameter int CNT_WIDTH        = 10
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [CNT_WIDTH-1:0]        h_cnt_i,
   input  logic [CNT_WIDTH-1:0]        v_cnt_i,
   input  logic                        line_end_i,
   input  logic [1:0]                  buff_fill_done_i,
   output logic [1:0]                  buff_fill_req_o,
   output logic [ROW_WIDTH-1:0]        fill_row_o,
   output logic [1:0]                  buff_sel_o,
   output logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_o,
   output logic                        underrun_o
);

   localparam logic [2:0] ST_RESET   = vga_pkg::RESET;
   localparam logic [2:0] ST_PRIME_0 = vga_pkg::PRIME_0;
   localparam logic [2:0] ST_PRIME_1 = vga_pkg::PRIME_1;
   localparam logic [2:0] ST_WAIT    = vga_pkg::WAIT_FRAME;
   localparam logic [2:0] ST_ACTIVE  = vga_pkg::ACTIVE;

   localparam int LIT_W   = $clog2(TILE_WIDTH);
   localparam int TW_LOG2 = $clog2(TILE_WIDTH);

   localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);
   localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(HEIGHT_PX - 1);
   localparam logic [CNT_WIDTH-1:0] H_VIS  = CNT_WIDTH'(HEIGHT_PX);
   localparam logic [CNT_WIDTH-1:0] W_VIS  = CNT_WIDTH'(WIDTH_PX);
   localparam logic [LIT_W-1:0]     LIT_MAX = LIT_W'(TILE_WIDTH - 1);
   localparam logic [ROW_WIDTH-1:0] ROW_LIM = ROW_WIDTH'(TILE_ROWS - 2);

   logic [2:0]                  state_q, state_d;
   logic [1:0]                  valid_q, valid_d;
   logic [1:0]                  req_q, req_d;
   logic [ROW_WIDTH-1:0]        frow_q, frow_d;
   logic                        idx_q, idx_d;
   logic [LIT_W-1:0]            lit_q, lit_d;
   logic [ROW_WIDTH-1:0]        drow_q, drow_d;
   logic                        unr_q, unr_d;
   logic [LBUFF_ADDR_WIDTH-1:0] pxl_q, pxl_d;
   logic [1:0]                  done_hit;
   logic                        new_idx;

   assign new_idx = ~idx_q;

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      req_d    = req_q;
      frow_d   = frow_q;
      idx_d    = idx_q;
      lit_d    = lit_q;
      drow_d   = drow_q;
      unr_d    = unr_q;
      done_hit = req_q & buff_fill_done_i;
      case (state_q)
         ST_RESET: begin
            state_d = ST_PRIME_0;
            valid_d = 2'b00;
            req_d   = 2'b01;
            frow_d  = '0;
         end
         ST_PRIME_0: begin
            if (buff_fill_done_i[0]) begin
               valid_d[0] = 1'b1;
               req_d      = 2'b10;
               frow_d     = ROW_WIDTH'(1);
               state_d    = ST_PRIME_1;
            end
         end
         ST_PRIME_1: begin
            if (buff_fill_done_i[1]) begin
               valid_d[1] = 1'b1;
               req_d      = 2'b00;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (line_end_i && v_cnt_i == V_LAST) begin
               state_d = ST_ACTIVE;
               idx_d   = 1'b0;
               drow_d  = '0;
               lit_d   = '0;
            end
         end
         ST_ACTIVE: begin
            // fills land before the swap so a same-cycle done is not an underrun
            valid_d = valid_q | done_hit;
            req_d   = req_q & ~done_hit;
            if (line_end_i && v_cnt_i < H_VIS) begin
               if (v_cnt_i == H_LAST) begin
                  state_d = ST_PRIME_0;
                  valid_d = 2'b00;
                  req_d   = 2'b01;
                  frow_d  = '0;
               end else if (lit_q != LIT_MAX) begin
                  lit_d = lit_q + LIT_W'(1);
               end else begin
                  lit_d          = '0;
                  drow_d         = drow_q + ROW_WIDTH'(1);
                  idx_d          = new_idx;
                  valid_d[idx_q] = 1'b0;
                  if (!valid_d[new_idx]) unr_d = 1'b1;
                  req_d = 2'b00;
                  if (drow_q < ROW_LIM) begin
                     req_d[idx_q] = 1'b1;
                     frow_d       = drow_q + ROW_WIDTH'(2);
                  end
               end
            end
         end
         default: state_d = ST_RESET;
      endcase
   end

   always_comb begin
      pxl_d = '0;
      if (h_cnt_i < W_VIS) pxl_d = LBUFF_ADDR_WIDTH'(h_cnt_i >> TW_LOG2);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_RESET;
         valid_q <= 2'b00;
         req_q   <= 2'b00;
         frow_q  <= '0;
         idx_q   <= 1'b0;
         lit_q   <= '0;
         drow_q  <= '0;
         unr_q   <= 1'b0;
         pxl_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         frow_q  <= frow_d;
         idx_q   <= idx_d;
         lit_q   <= lit_d;
         drow_q  <= drow_d;
         unr_q   <= unr_d;
         pxl_q   <= pxl_d;
      end
   end

   assign buff_fill_req_o = req_q;
   assign fill_row_o      = frow_q;
   assign disp_pxl_id_o   = pxl_q;
   assign underrun_o      = unr_q;
   assign buff_sel_o      = (state_q == ST_ACTIVE && v_cnt_i < H_VIS)
                          ? (idx_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
